// File: rtl/milano_pkg.sv
// Shared types and constants for the milano core.
//   pipe_state_e     : pipeline sequencing controller FSM states.
//   PIPE_FLUSH_CNT_W : width of the controller's multi-cycle flush down-counter.
package milano_pkg;

  typedef enum logic [1:0] {
    PIPE_RUN      = 2'd0,
    PIPE_MEM_WAIT = 2'd1,
    PIPE_FLUSH    = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_FLUSH_CNT_W = 8;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counter.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears the count
//   inc_i  : increment by one this cycle
//   cnt_o  : current count, holds at all-ones
module pipe_perf_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: produces stall/flush controls for the PC, IF/ID and ID/EX
// registers for taken jumps, LSU handshake waits and load-use hazards, plus saturating
// stall/flush performance counters.
//   clk_i, rst_ni                      : clock, asynchronous active-low reset
//   id_valid_i, id_rs*_addr_i/used_i   : source operands of the instruction in ID
//   ex_rd_addr_i, ex_rd_wr_en_i        : destination of the instruction in EX
//   ex_lsu_req_i, ex_lsu_we_i          : EX memory access and whether it is a store
//   ex_jump_taken_i                    : EX resolved a taken jump/branch
//   lsu_gnt_i, lsu_rvalid_i            : data memory grant / load data return
//   pc_stall_o, if_id_*_o, id_ex_*_o   : pipeline register controls (combinational)
//   state_o                            : current FSM state (debug)
//   stall_cnt_o, flush_cnt_o           : saturating perf counters
module pipe_ctrl
  import milano_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wr_en_i,
  input  logic             ex_lsu_req_i,
  input  logic             ex_lsu_we_i,
  input  logic             ex_jump_taken_i,
  input  logic             lsu_gnt_i,
  input  logic             lsu_rvalid_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output pipe_state_e      state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [PIPE_FLUSH_CNT_W-1:0] FlushInit = PIPE_FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [PIPE_FLUSH_CNT_W-1:0] FlushOne  = PIPE_FLUSH_CNT_W'(1);

  pipe_state_e                 state_q, state_d;
  logic [PIPE_FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load, hazard, rs1_match, rs2_match;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic flush_evt;

  assign load      = ex_lsu_req_i & ~ex_lsu_we_i;
  assign rs1_match = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_match = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
  assign hazard    = id_valid_i & ex_rd_wr_en_i & (ex_rd_addr_i != 5'd0) & (rs1_match | rs2_match);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    flush_evt   = 1'b0;

    unique case (state_q)
      PIPE_RUN: begin
        if (ex_jump_taken_i) begin
          // Wrong-path instructions in IF/ID and ID: flush wins over any hazard.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_evt   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = PIPE_FLUSH;
            flush_cnt_d = FlushInit;
          end
        end else if (ex_lsu_req_i && !lsu_gnt_i) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
        end else if (load && lsu_gnt_i) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          state_d     = PIPE_MEM_WAIT;
        end
      end

      PIPE_MEM_WAIT: begin
        if (!lsu_rvalid_i) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
        end else begin
          // Load data arrives now; a dependent ID instruction gets one bubble behind it.
          if (hazard) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
          state_d = PIPE_RUN;
        end
      end

      PIPE_FLUSH: begin
        // EX holds a bubble here, so all other inputs are ignored.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_cnt_d = flush_cnt_q - FlushOne;
        if (flush_cnt_q == FlushOne) begin
          state_d = PIPE_RUN;
        end
      end

      default: begin
        state_d = PIPE_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PIPE_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are forced low while reset is asserted, regardless of the inputs.
  assign pc_stall_o    = rst_ni & pc_stall;
  assign if_id_stall_o = rst_ni & if_id_stall;
  assign if_id_flush_o = rst_ni & if_id_flush;
  assign id_ex_stall_o = rst_ni & id_ex_stall;
  assign id_ex_flush_o = rst_ni & id_ex_flush;
  assign state_o       = state_q;

  pipe_perf_cnt #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (pc_stall_o),
    .cnt_o  (stall_cnt_o)
  );

  pipe_perf_cnt #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (rst_ni & flush_evt),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Two instances share the stimulus:
//   dut  : FLUSH_CYCLES=2, CNT_W=4 (multi-cycle flush, counter saturation at 15)
//   dut1 : FLUSH_CYCLES=1, CNT_W=8 (single-cycle flush, wider counter)
// Control vectors are packed {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}.
module tb_pipe_ctrl;
  import milano_pkg::*;

  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_STALL  = 5'b11010;
  localparam logic [4:0] C_BUBBLE = 5'b11001;
  localparam logic [4:0] C_FLUSH  = 5'b00101;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       id_valid, rs1_used, rs2_used, rd_wr_en, lsu_req, lsu_we, jump, gnt, rvalid;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;

  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  pipe_state_e state;
  logic [3:0]  stall_cnt, flush_cnt;
  logic        pc_stall1, if_id_stall1, if_id_flush1, id_ex_stall1, id_ex_flush1;
  pipe_state_e state1;
  logic [7:0]  stall_cnt1, flush_cnt1;
  logic [4:0]  ctrl, ctrl1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  assign ctrl  = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush};
  assign ctrl1 = {pc_stall1, if_id_stall1, if_id_flush1, id_ex_stall1, id_ex_flush1};

  pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(rd_addr), .ex_rd_wr_en_i(rd_wr_en),
    .ex_lsu_req_i(lsu_req), .ex_lsu_we_i(lsu_we), .ex_jump_taken_i(jump),
    .lsu_gnt_i(gnt), .lsu_rvalid_i(rvalid),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush), .state_o(state),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(8)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(rd_addr), .ex_rd_wr_en_i(rd_wr_en),
    .ex_lsu_req_i(lsu_req), .ex_lsu_we_i(lsu_we), .ex_jump_taken_i(jump),
    .lsu_gnt_i(gnt), .lsu_rvalid_i(rvalid),
    .pc_stall_o(pc_stall1), .if_id_stall_o(if_id_stall1), .if_id_flush_o(if_id_flush1),
    .id_ex_stall_o(id_ex_stall1), .id_ex_flush_o(id_ex_flush1), .state_o(state1),
    .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; rs1_used = 0; rs2_used = 0; rd_wr_en = 0;
    lsu_req = 0; lsu_we = 0; jump = 0; gnt = 0; rvalid = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    clear_inputs();
    #3;
    check("reset_ctrl", 32'(ctrl), 32'(C_NONE));
    check("reset_state", 32'(state), 32'(PIPE_RUN));
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    tick();
    rst_ni = 1;

    // Load x5 with gnt now, rvalid two cycles later; ID add reads x5.
    tick();
    id_valid = 1; rs1_addr = 5; rs1_used = 1; rs2_addr = 7; rs2_used = 1;
    rd_addr = 5; rd_wr_en = 1; lsu_req = 1; lsu_we = 0; gnt = 1;
    #1;
    check("lu_gnt_ctrl", 32'(ctrl), 32'(C_STALL));
    tick();
    gnt = 0;
    #1;
    check("lu_wait_state", 32'(state), 32'(PIPE_MEM_WAIT));
    check("lu_wait_ctrl", 32'(ctrl), 32'(C_STALL));
    tick();
    rvalid = 1;
    #1;
    check("lu_bubble_ctrl", 32'(ctrl), 32'(C_BUBBLE));
    tick();
    clear_inputs();
    #1;
    check("lu_done_state", 32'(state), 32'(PIPE_RUN));
    check("lu_done_ctrl", 32'(ctrl), 32'(C_NONE));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd3);
    check("lu_stall_cnt1", 32'(stall_cnt1), 32'd3);

    // Load to x0, ID reads x0 through rs2: no bubble when data returns.
    id_valid = 1; rs2_addr = 0; rs2_used = 1; rd_addr = 0; rd_wr_en = 1;
    lsu_req = 1; gnt = 1;
    #1;
    check("x0_gnt_ctrl", 32'(ctrl), 32'(C_STALL));
    tick();
    gnt = 0; rvalid = 1;
    #1;
    check("x0_rvalid_ctrl", 32'(ctrl), 32'(C_NONE));
    tick();
    clear_inputs();
    #1;
    check("x0_state", 32'(state), 32'(PIPE_RUN));
    check("x0_stall_cnt", 32'(stall_cnt), 32'd4);

    // Store with gnt delayed three cycles: stalls, never enters PIPE_MEM_WAIT.
    lsu_req = 1; lsu_we = 1; gnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_wait_ctrl", 32'(ctrl), 32'(C_STALL));
      check("st_wait_state", 32'(state), 32'(PIPE_RUN));
      tick();
    end
    gnt = 1;
    #1;
    check("st_gnt_ctrl", 32'(ctrl), 32'(C_NONE));
    tick();
    clear_inputs();
    #1;
    check("st_state", 32'(state), 32'(PIPE_RUN));
    check("st_stall_cnt", 32'(stall_cnt), 32'd7);

    // Taken jump with a load-use hazard and a granted load also present.
    jump = 1; id_valid = 1; rs1_addr = 9; rs1_used = 1; rd_addr = 9; rd_wr_en = 1;
    lsu_req = 1; gnt = 1;
    #1;
    check("jmp_c0_ctrl", 32'(ctrl), 32'(C_FLUSH));
    check("jmp_c0_ctrl1", 32'(ctrl1), 32'(C_FLUSH));
    tick();
    // Second jump in this cycle: ignored by dut (in PIPE_FLUSH), taken by dut1.
    lsu_req = 0; gnt = 0;
    #1;
    check("jmp_c1_state", 32'(state), 32'(PIPE_FLUSH));
    check("jmp_c1_ctrl", 32'(ctrl), 32'(C_FLUSH));
    check("jmp_c1_state1", 32'(state1), 32'(PIPE_RUN));
    check("jmp_c1_ctrl1", 32'(ctrl1), 32'(C_FLUSH));
    tick();
    clear_inputs();
    #1;
    check("jmp_end_state", 32'(state), 32'(PIPE_RUN));
    check("jmp_end_ctrl", 32'(ctrl), 32'(C_NONE));
    check("jmp_flush_cnt", 32'(flush_cnt), 32'd1);
    check("jmp_flush_cnt1", 32'(flush_cnt1), 32'd2);
    check("jmp_stall_cnt", 32'(stall_cnt), 32'd7);

    // Reset for one cycle while waiting for load data.
    id_valid = 1; rs1_addr = 3; rs1_used = 1; rd_addr = 3; rd_wr_en = 1;
    lsu_req = 1; gnt = 1;
    tick();
    gnt = 0;
    #1;
    check("rst_pre_state", 32'(state), 32'(PIPE_MEM_WAIT));
    rst_ni = 0;
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(C_NONE));
    check("rst_state", 32'(state), 32'(PIPE_RUN));
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    tick();
    clear_inputs();
    rst_ni = 1;
    #1;
    check("rst_post_ctrl", 32'(ctrl), 32'(C_NONE));
    check("rst_post_state", 32'(state), 32'(PIPE_RUN));

    // Continuous stall: 4-bit counter saturates at 15, 8-bit keeps counting.
    lsu_req = 1; lsu_we = 1; gnt = 0;
    repeat (15) tick();
    check("sat_cnt_15", 32'(stall_cnt), 32'd15);
    repeat (5) tick();
    check("sat_cnt_hold", 32'(stall_cnt), 32'd15);
    check("sat_cnt1_20", 32'(stall_cnt1), 32'd20);
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
